// File: rtl/alu_pkg.sv
// Shared ALU definitions: opsel encodings and execute-stage FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Both shift encodings share opsel[1:0] == 01; opsel[2] selects right shift.
  function automatic logic is_shift(input logic [2:0] opsel);
    return opsel[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/alu_compare.sv
// Combinational comparator: equality plus signed and unsigned less-than.
// Shared with the branch unit.
module alu_compare #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq_c,
  output logic            lts_c,
  output logic            ltu_c
);

  // Compare both interpretations; callers pick the one they need.
  always_comb begin
    eq_c  = (a == b);
    ltu_c = (a < b);
    lts_c = ($signed(a) < $signed(b));
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle add/logic/compare, bit-serial shifts,
// result held behind a valid/ready handshake together with branch flags.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_eq,
  output logic            o_lt
);

  state_t          state, state_d;
  logic [XLEN-1:0] result_d;
  logic            eq_d, lt_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            fill_q, fill_d;

  logic            eq_c, lts_c, ltu_c, lt_sel_c;
  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] shstep_c;

  alu_compare #(.XLEN(XLEN)) u_cmp (
    .a     (i_op1),
    .b     (i_op2),
    .eq_c  (eq_c),
    .lts_c (lts_c),
    .ltu_c (ltu_c)
  );

  // Single-cycle datapath result; shift encodings are handled by the FSM.
  always_comb begin
    lt_sel_c = i_unsigned ? ltu_c : lts_c;
    alu_c    = '0;
    case (i_opsel)
      OP_ADD:  alu_c = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
      OP_SLT:  alu_c = XLEN'(lts_c);
      OP_SLTU: alu_c = XLEN'(lt_sel_c);
      OP_XOR:  alu_c = i_op1 ^ i_op2;
      OP_OR:   alu_c = i_op1 | i_op2;
      OP_AND:  alu_c = i_op1 & i_op2;
      default: alu_c = '0;
    endcase
  end

  // One-bit shift step: right shifts fill with the latched fill bit.
  always_comb begin
    shstep_c = dir_q ? {fill_q, shreg_q[XLEN-1:1]} : {shreg_q[XLEN-2:0], 1'b0};
  end

  // Next-state and datapath-update logic.
  always_comb begin
    state_d  = state;
    result_d = o_result;
    eq_d     = o_eq;
    lt_d     = o_lt;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    case (state)
      IDLE: begin
        if (i_valid) begin
          eq_d = eq_c;
          lt_d = lt_sel_c;
          if (is_shift(i_opsel)) begin
            shreg_d = i_op1;
            cnt_d   = i_op2[SHW-1:0];
            dir_d   = i_opsel[2];
            fill_d  = i_opsel[2] & i_arith & i_op1[XLEN-1];
            if (i_op2[SHW-1:0] == '0) begin
              result_d = i_op1;
              state_d  = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            result_d = alu_c;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        shreg_d = shstep_c;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = shstep_c;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_result <= '0;
      o_eq     <= 1'b0;
      o_lt     <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state    <= state_d;
      o_result <= result_d;
      o_eq     <= eq_d;
      o_lt     <= lt_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      fill_q   <= fill_d;
    end
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed self-checking bench for alu_iter_exec.
module tb_alu_iter_exec;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_opsel = 3'b000;
  logic        i_sub = 1'b0;
  logic        i_unsigned = 1'b0;
  logic        i_arith = 1'b0;
  logic [31:0] i_op1 = '0;
  logic [31:0] i_op2 = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_result;
  logic        o_eq;
  logic        o_lt;

  int total = 0;
  int passed = 0;

  alu_iter_exec #(.XLEN(32)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_opsel    (i_opsel),
    .i_sub      (i_sub),
    .i_unsigned (i_unsigned),
    .i_arith    (i_arith),
    .i_op1      (i_op1),
    .i_op2      (i_op2),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_eq       (o_eq),
    .o_lt       (o_lt)
  );

  always #5 i_clk = ~i_clk;

  // Issue one op with i_ready high; report result, flags, latency and o_ready-low cycles.
  task automatic run_op(input logic [2:0] op, input logic sub, input logic uns, input logic ari,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic eq, output logic lt,
                        output int lat, output int low);
    int g;
    lat = 0;
    low = 0;
    res = 'x;
    eq  = 1'bx;
    lt  = 1'bx;
    g = 0;
    while (!o_ready && g < 100) begin
      @(posedge i_clk); #1;
      g++;
    end
    i_opsel = op; i_sub = sub; i_unsigned = uns; i_arith = ari; i_op1 = a; i_op2 = b;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (!o_ready) low++;
      if (o_valid && lat == 0) begin
        lat = k; res = o_result; eq = o_eq; lt = o_lt;
      end
      if (o_ready) break;
      @(posedge i_clk); #1;
    end
    total++;
    if (lat == 0) $display("FAIL timeout op=%b: o_valid never rose within 100 cycles", op);
    else passed++;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    total++;
    if ({o_valid, o_ready, o_eq, o_lt} !== 4'b0100 || o_result !== 32'h0)
      $display("FAIL reset: valid=%b ready=%b eq=%b lt=%b result=%h, required 0 1 0 0 00000000",
               o_valid, o_ready, o_eq, o_lt, o_result);
    else passed++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_add_sub();
    logic [31:0] r; logic e, l; int lat, low;
    run_op(3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, r, e, l, lat, low);
    total++;
    if (r !== 32'h0000000C || e !== 1'b0 || l !== 1'b1 || lat != 1)
      $display("FAIL add: result=%h eq=%b lt=%b lat=%0d, required 0000000c 0 1 1", r, e, l, lat);
    else passed++;
    run_op(3'b000, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1, r, e, l, lat, low);
    total++;
    if (r !== 32'hFFFFFFFF || l !== 1'b1 || lat != 1)
      $display("FAIL sub_wrap: result=%h lt=%b lat=%0d, required ffffffff 1 1", r, l, lat);
    else passed++;
    // i_sub ignored for non-add opsel; equal operands raise eq
    run_op(3'b100, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, r, e, l, lat, low);
    total++;
    if (r !== 32'h0 || e !== 1'b1 || l !== 1'b0)
      $display("FAIL xor_eq: result=%h eq=%b lt=%b, required 00000000 1 0", r, e, l);
    else passed++;
  endtask

  task automatic test_logic();
    logic [31:0] r; logic e, l; int lat, low;
    run_op(3'b100, 1'b0, 1'b0, 1'b0, 32'hF0F01234, 32'h0FF000FF, r, e, l, lat, low);
    total++;
    if (r !== 32'hFF0012CB) $display("FAIL xor: result=%h, required ff0012cb", r);
    else passed++;
    run_op(3'b110, 1'b0, 1'b0, 1'b0, 32'hF0F01234, 32'h0FF000FF, r, e, l, lat, low);
    total++;
    if (r !== 32'hFFF012FF) $display("FAIL or: result=%h, required fff012ff", r);
    else passed++;
    run_op(3'b111, 1'b0, 1'b0, 1'b0, 32'hF0F01234, 32'h0FF000FF, r, e, l, lat, low);
    total++;
    if (r !== 32'h00F00034) $display("FAIL and: result=%h, required 00f00034", r);
    else passed++;
  endtask

  task automatic test_shift();
    logic [31:0] r; logic e, l; int lat, low;
    run_op(3'b101, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd4, r, e, l, lat, low);
    total++;
    if (r !== 32'hF8000000 || low != 5 || lat != 5)
      $display("FAIL sra: result=%h ready_low=%0d lat=%0d, required f8000000 5 5", r, low, lat);
    else passed++;
    run_op(3'b101, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'd4, r, e, l, lat, low);
    total++;
    if (r !== 32'h08000000 || lat != 5)
      $display("FAIL srl: result=%h lat=%0d, required 08000000 5", r, lat);
    else passed++;
    run_op(3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'h25, r, e, l, lat, low);
    total++;
    if (r !== 32'h00000020 || lat != 6)
      $display("FAIL sll_mask: result=%h lat=%0d, required 00000020 6", r, lat);
    else passed++;
    run_op(3'b001, 1'b0, 1'b0, 1'b0, 32'd1, 32'h20, r, e, l, lat, low);
    total++;
    if (r !== 32'h00000001 || lat != 1)
      $display("FAIL sll_zero: result=%h lat=%0d, required 00000001 1", r, lat);
    else passed++;
  endtask

  task automatic test_compare();
    logic [31:0] r; logic e, l; int lat, low;
    run_op(3'b011, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, r, e, l, lat, low);
    total++;
    if (r !== 32'h0 || l !== 1'b0)
      $display("FAIL sltu: result=%h lt=%b, required 00000000 0", r, l);
    else passed++;
    run_op(3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, r, e, l, lat, low);
    total++;
    if (r !== 32'h1 || l !== 1'b1)
      $display("FAIL slt_signed: result=%h lt=%b, required 00000001 1", r, l);
    else passed++;
    // opsel 010 stays signed even with i_unsigned set; o_lt follows i_unsigned
    run_op(3'b010, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, r, e, l, lat, low);
    total++;
    if (r !== 32'h1 || l !== 1'b0)
      $display("FAIL slt_always_signed: result=%h lt=%b, required 00000001 0", r, l);
    else passed++;
  endtask

  task automatic test_backpressure();
    int g;
    i_ready = 1'b0;
    i_opsel = 3'b000; i_sub = 1'b0; i_op1 = 32'd3; i_op2 = 32'd4;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    g = 0;
    while (!o_valid && g < 20) begin
      @(posedge i_clk); #1;
      g++;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'd7)
        $display("FAIL hold_%0d: valid=%b ready=%b result=%h, required 1 0 00000007",
                 i, o_valid, o_ready, o_result);
      else passed++;
      i_opsel = 3'b110; i_op1 = 32'h12345678; i_op2 = 32'h0F0F0F0F; i_valid = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'd7)
      $display("FAIL handshake: valid=%b ready=%b result=%h, required 0 1 00000007",
               o_valid, o_ready, o_result);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] r; logic e, l; int lat, low;
    i_opsel = 3'b001; i_op1 = 32'd1; i_op2 = 32'd31; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_result !== 32'h0)
      $display("FAIL reset_abort: valid=%b result=%h, required 0 00000000", o_valid, o_result);
    else passed++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL after_release: ready=%b valid=%b, required 1 0", o_ready, o_valid);
    else passed++;
    run_op(3'b000, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'd1, r, e, l, lat, low);
    total++;
    if (r !== 32'h80000000 || l !== 1'b0)
      $display("FAIL post_reset_add: result=%h lt=%b, required 80000000 0", r, l);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_shift();
    test_compare();
    test_backpressure();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU that consumes the control word produced by the ALU decode logic: opsel, sub, unsigned and arith.
- Add, logic and compare ops finish in one cycle. Shifts are iterative, one bit per cycle.
- Results are buffered behind a valid/ready handshake so the hart can stall either side.
- Also produces the registered branch flags (eq, lt).

Parameters:
XLEN, 32, operand/result width; power of two, >= 8
SHW, $clog2(XLEN), shift-amount width taken from i_op2[SHW-1:0]

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream op valid
o_ready  out  1  unit can accept an op (high only in IDLE)
i_opsel  in  3  000 add/sub, 001 sll, 010 slt, 011 slt/sltu, 100 xor, 101 srl/sra, 110 or, 111 and
i_sub  in  1  subtract; honoured only for opsel 000
i_unsigned  in  1  unsigned compare for opsel 011 and for o_lt
i_arith  in  1  arithmetic right shift; honoured only for opsel 101
i_op1  in  XLEN  operand 1 / shift source
i_op2  in  XLEN  operand 2 / shift amount
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_result  out  XLEN  result, stable while o_valid high
o_eq  out  1  registered i_op1 == i_op2
o_lt  out  1  registered i_op1 < i_op2; signed, or unsigned if i_unsigned

Behaviour:
- Reset (async, i_rst_n low): state IDLE, o_valid=0, o_result=0, o_eq=0, o_lt=0, shift reg=0, count=0.
  - Reset mid-operation aborts it; the result is discarded.
- FSM states: IDLE, SHIFT, DONE. o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE, accept on i_valid && o_ready:
  - Latch o_eq and o_lt from the operands.
  - Non-shift opsel: register the combinational result, go to DONE. o_valid is high the next cycle (latency 1).
  - Shift opsel (001/101): load shreg=i_op1, cnt=i_op2[SHW-1:0], latch direction and fill bit (i_arith & i_op1[XLEN-1] for 101, else 0).
    - cnt==0: o_result=i_op1, go to DONE.
    - cnt!=0: go to SHIFT.
- SHIFT:
  - Each cycle shift shreg by 1 (left fills 0; right fills the fill bit) and decrement cnt.
  - When cnt reaches 1, write the final shifted value to o_result and go to DONE.
  - Total latency = shamt+1 cycles; o_ready is low for that many cycles.
- DONE: hold o_result/o_eq/o_lt stable. On i_ready go to IDLE. No new op is accepted in the same cycle (max throughput 1 op per 2 cycles).
- Arithmetic:
  - add/sub wraps modulo 2^XLEN.
  - opsel 010 is always a signed compare.
  - opsel 011 is unsigned when i_unsigned, else signed.
  - slt results are zero-extended to XLEN.
- Don't-cares:
  - i_sub ignored unless opsel 000; i_arith ignored unless opsel 101.
  - Inputs are ignored while o_ready is low; changes on them do not affect an op in flight.
  - i_ready is ignored outside DONE.

Decomposition:
- Shared package alu_pkg holds:
  - opsel localparams OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND;
  - state enum (IDLE/SHIFT/DONE).
- One combinational sub-module, alu_compare: eq, signed/unsigned lt. It is reused by the branch unit.

Test Plan:
- Add: op1=5, op2=7, opsel 000, sub=0 -> o_valid one cycle after accept, result 0x0000000C, eq=0, lt=1.
- Sub wrap: op1=0, op2=1, sub=1 -> result 0xFFFFFFFF.
- sra: op1=0x80000000, op2=4, opsel 101, arith=1 -> o_ready low 5 cycles, result 0xF8000000.
  - Same with arith=0 -> 0x08000000.
- Shift amount masking: sll op1=1, op2=0x25 -> result 0x20 after 6 cycles.
  - sll op2=0x20 (shamt 0) -> result 0x1 after 1 cycle.
- Compare: op1=0xFFFFFFFF, op2=1, opsel 011:
  - unsigned=1 -> result 0, lt=0;
  - unsigned=0 -> result 1, lt=1.
- Backpressure and reset:
  - Hold i_ready low 3 cycles in DONE -> result stable, i_valid ignored, handshake on the 4th cycle.
  - sll shamt 31, drop i_rst_n at SHIFT cycle 3 -> o_valid=0, o_result=0 immediately; o_ready=1 after release.
